vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable video timing generator: programmable H/V timing with
// frame-boundary shadowing, programmable sync polarity and pixel clock-enable.
module vga_timing_gen #(
  parameter int H_W      = 12,
  parameter int V_W      = 11,
  parameter int H_ACTIVE = 960,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 144,
  parameter int V_ACTIVE = 540,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 14,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  input  logic [H_W-1:0] cfg_h_active,
  input  logic [H_W-1:0] cfg_h_fp,
  input  logic [H_W-1:0] cfg_h_sync,
  input  logic [H_W-1:0] cfg_h_bp,
  input  logic [V_W-1:0] cfg_v_active,
  input  logic [V_W-1:0] cfg_v_fp,
  input  logic [V_W-1:0] cfg_v_sync,
  input  logic [V_W-1:0] cfg_v_bp,
  input  logic           cfg_hs_pol,
  input  logic           cfg_vs_pol,
  input  logic           cfg_load,
  output logic           cfg_pending,
  output logic           cfg_err,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           hsync,
  output logic           vsync,
  output logic           display_area,
  output logic [H_W-1:0] pixel_x,
  output logic [V_W-1:0] pixel_y,
  output logic           sof,
  output logic           eol
);

  typedef struct packed {
    logic [H_W-1:0] ha, hf, hs, hb;
    logic [V_W-1:0] va, vf, vs, vb;
    logic           hp, vp;
  } tcfg_t;

  localparam tcfg_t RST_CFG = '{
    ha: H_W'(H_ACTIVE), hf: H_W'(H_FP), hs: H_W'(H_SYNC), hb: H_W'(H_BP),
    va: V_W'(V_ACTIVE), vf: V_W'(V_FP), vs: V_W'(V_SYNC), vb: V_W'(V_BP),
    hp: HS_POL, vp: VS_POL
  };

  localparam logic [H_W+1:0] H_LIM = (H_W+2)'(1) << H_W;
  localparam logic [V_W+1:0] V_LIM = (V_W+2)'(1) << V_W;

  tcfg_t work, pend, cfg_in;

  logic [H_W+1:0] in_h_tot, h_tot, hs_beg, hs_end, hx;
  logic [V_W+1:0] in_v_tot, v_tot, vs_beg, vs_end, vx;
  logic           cfg_ok, load_ok, h_last, v_last, apply, h_in, v_in;

  always_comb begin
    cfg_in = '{
      ha: cfg_h_active, hf: cfg_h_fp, hs: cfg_h_sync, hb: cfg_h_bp,
      va: cfg_v_active, vf: cfg_v_fp, vs: cfg_v_sync, vb: cfg_v_bp,
      hp: cfg_hs_pol, vp: cfg_vs_pol
    };
    in_h_tot = (H_W+2)'(cfg_h_active) + (H_W+2)'(cfg_h_fp)
             + (H_W+2)'(cfg_h_sync) + (H_W+2)'(cfg_h_bp);
    in_v_tot = (V_W+2)'(cfg_v_active) + (V_W+2)'(cfg_v_fp)
             + (V_W+2)'(cfg_v_sync) + (V_W+2)'(cfg_v_bp);
    cfg_ok   = (|cfg_h_active) && (|cfg_v_active)
            && (in_h_tot <= H_LIM) && (in_v_tot <= V_LIM);
    load_ok  = cfg_load && cfg_ok;
  end

  // Timing decode from the working set; sums are wide enough to never wrap.
  always_comb begin
    hs_beg = (H_W+2)'(work.ha) + (H_W+2)'(work.hf);
    hs_end = hs_beg + (H_W+2)'(work.hs);
    h_tot  = hs_end + (H_W+2)'(work.hb);
    vs_beg = (V_W+2)'(work.va) + (V_W+2)'(work.vf);
    vs_end = vs_beg + (V_W+2)'(work.vs);
    v_tot  = vs_end + (V_W+2)'(work.vb);
    hx     = (H_W+2)'(h_cnt);
    vx     = (V_W+2)'(v_cnt);
    h_last = (hx == h_tot - 1'b1);
    v_last = (vx == v_tot - 1'b1);
    h_in   = (hx >= hs_beg) && (hx < hs_end);
    v_in   = (vx >= vs_beg) && (vx < vs_end);
    apply  = pix_en && h_last && v_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work         <= RST_CFG;
      pend         <= RST_CFG;
      cfg_pending  <= 1'b0;
      cfg_err      <= 1'b0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      hsync        <= ~RST_CFG.hp;
      vsync        <= ~RST_CFG.vp;
      display_area <= 1'b0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      sof          <= 1'b0;
      eol          <= 1'b0;
    end else begin
      if (cfg_load) begin
        cfg_err <= ~cfg_ok;
        if (cfg_ok) pend <= cfg_in;
      end
      // pend always equals work when nothing is pending, so apply is unconditional
      if (apply) work <= load_ok ? cfg_in : pend;
      if (load_ok)    cfg_pending <= ~apply;
      else if (apply) cfg_pending <= 1'b0;

      if (pix_en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
        hsync        <= h_in ? work.hp : ~work.hp;
        vsync        <= v_in ? work.vp : ~work.vp;
        display_area <= (hx < (H_W+2)'(work.ha)) && (vx < (V_W+2)'(work.va));
        pixel_x      <= h_cnt;
        pixel_y      <= v_cnt;
        sof          <= (h_cnt == '0) && (v_cnt == '0);
        eol          <= h_last;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; vertical reset timing shrunk to 3/1/1/1
// so that full default frames fit a short run.
module tb_vga_timing_gen;
  localparam int H_W = 12;
  localparam int V_W = 11;

  logic clk = 1'b0;
  logic rst, pix_en, cfg_load, cfg_hs_pol, cfg_vs_pol;
  logic [H_W-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [V_W-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic cfg_pending, cfg_err, hsync, vsync, display_area, sof, eol;
  logic [H_W-1:0] h_cnt, pixel_x;
  logic [V_W-1:0] v_cnt, pixel_y;

  always #5 clk = ~clk;

  vga_timing_gen #(.V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync(hsync), .vsync(vsync), .display_area(display_area),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .sof(sof), .eol(eol)
  );

  int n_chk = 0, n_err = 0;
  int de_n, sof_n, hs_n, vs_n;
  logic [H_W-1:0] eh;
  logic [V_W-1:0] ev;
  logic [63:0]    ex;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    #1;
    pix_en   = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input logic hp, vp);
    cfg_h_active = H_W'(ha); cfg_h_fp = H_W'(hf); cfg_h_sync = H_W'(hs); cfg_h_bp = H_W'(hb);
    cfg_v_active = V_W'(va); cfg_v_fp = V_W'(vf); cfg_v_sync = V_W'(vs); cfg_v_bp = V_W'(vb);
    cfg_hs_pol = hp; cfg_vs_pol = vp;
  endtask

  task automatic load_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input logic hp, vp);
    set_cfg(ha, hf, hs, hb, va, vf, vs, vb, hp, vp);
    cfg_load = 1'b1;
    step(1'b0);
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({h_cnt, v_cnt, hsync, vsync, display_area, sof, eol, pixel_x, pixel_y});
  endfunction

  // Small timing 8/2/3/3 x 4/1/2/1, both syncs active-high; one tick per `per` clocks.
  task automatic scan(input int n, input int per);
    logic [H_W-1:0] nh;
    logic [V_W-1:0] nv;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < per; k++) begin
        step(k == 0);
        if (k == 0) begin
          nh = (eh == 15) ? '0 : eh + 1'b1;
          nv = (eh != 15) ? ev : (ev == 7) ? '0 : ev + 1'b1;
          ex = 64'({nh, nv, (eh >= 10 && eh < 13), (ev >= 5 && ev < 7),
                    (eh < 8 && ev < 4), (eh == 0 && ev == 0), (eh == 15), eh, ev});
          eh = nh;
          ev = nv;
          de_n += int'(display_area); sof_n += int'(sof);
          hs_n += int'(hsync);        vs_n  += int'(vsync);
        end
        check("scan", dut_vec(), ex);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b0); step(1'b0);
    rst = 1'b0;
    check("rst_vec", dut_vec(), 64'({12'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 11'd0}));
    check("rst_cfg", {cfg_pending, cfg_err}, 2'b00);

    // default horizontal timing
    ticks(1);
    check("t1_vec", dut_vec(), 64'({12'd1, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 11'd0}));
    ticks(1007);
    check("h1008_hs", {h_cnt, hsync, display_area}, {12'd1008, 1'b1, 1'b0});
    ticks(1);
    check("h1009_hs", hsync, 1'b0);
    ticks(95);
    check("h1104_hs", {h_cnt, hsync}, {12'd1104, 1'b0});
    ticks(1);
    check("h1105_hs", hsync, 1'b1);
    ticks(143);
    check("wrap_eol", {h_cnt, v_cnt, eol, pixel_x}, {12'd0, 11'd1, 1'b1, 12'd1247});

    // mid-frame load waits for the frame boundary
    load_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
    check("mid_pend", {cfg_pending, cfg_err, h_cnt}, {1'b1, 1'b0, 12'd0});
    ticks(3744);
    check("l4_vs_pre", {v_cnt, vsync}, {11'd4, 1'b1});
    ticks(1);
    check("l4_vs", vsync, 1'b0);
    ticks(1248);
    check("l5_vs", {v_cnt, vsync}, {11'd5, 1'b1});
    ticks(1246);
    check("pre_apply", {cfg_pending, h_cnt, v_cnt}, {1'b1, 12'd1247, 11'd5});
    ticks(1);
    check("apply", {cfg_pending, h_cnt, v_cnt, eol, sof}, {1'b0, 12'd0, 11'd0, 1'b1, 1'b0});

    // one full small frame, per-tick
    eh = '0; ev = '0; de_n = 0; sof_n = 0; hs_n = 0; vs_n = 0;
    scan(128, 1);
    check("de_cnt", de_n, 32);
    check("sof_cnt", sof_n, 1);
    check("hs_cnt", hs_n, 24);
    check("vs_cnt", vs_n, 32);

    // 1-in-3 pix_en: same sequence, held between ticks
    scan(48, 3);

    // rejected loads leave pending state and timing alone
    load_cfg(0, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0);
    check("rej_ha0", {cfg_err, cfg_pending}, 2'b10);
    ticks(16);
    check("rej_timing", {h_cnt, v_cnt}, {12'd0, 11'd4});
    load_cfg(8, 2, 3, 3, 2040, 5, 5, 5, 1'b0, 1'b0);
    check("rej_vsum", {cfg_err, cfg_pending}, 2'b10);
    load_cfg(4000, 50, 50, 50, 4, 1, 2, 1, 1'b0, 1'b0);
    check("rej_hsum", {cfg_err, cfg_pending}, 2'b10);
    load_cfg(4000, 32, 32, 32, 4, 1, 2, 1, 1'b0, 1'b0);
    check("acc_4096", {cfg_err, cfg_pending}, 2'b01);
    load_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1);
    check("overwrite", {cfg_err, cfg_pending}, 2'b01);
    ticks(63);
    check("c2_pre", {cfg_pending, h_cnt, v_cnt}, {1'b1, 12'd15, 11'd7});
    ticks(1);
    check("c2_apply", {cfg_pending, h_cnt, v_cnt}, {1'b0, 12'd0, 11'd0});
    ticks(8);
    check("c2_hs", {h_cnt, hsync, vsync}, {12'd8, 1'b0, 1'b0});
    ticks(2);
    check("c2_wrap", {h_cnt, v_cnt, hsync, eol}, {12'd0, 11'd1, 1'b1, 1'b1});

    // load exactly on the apply tick
    ticks(49);
    check("co_pre", {h_cnt, v_cnt}, {12'd9, 11'd5});
    set_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
    cfg_load = 1'b1;
    step(1'b1);
    check("co_apply", {cfg_pending, cfg_err, h_cnt, v_cnt}, {1'b0, 1'b0, 12'd0, 11'd0});
    ticks(11);
    check("co_hs", {h_cnt, hsync}, {12'd11, 1'b1});
    ticks(5);
    check("co_wrap", {h_cnt, v_cnt}, {12'd0, 11'd1});

    // reset discards a pending config
    load_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1);
    check("rp_pend", cfg_pending, 1'b1);
    ticks(3);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    check("rp_vec", dut_vec(), 64'({12'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 11'd0}));
    check("rp_cfg", {cfg_pending, cfg_err}, 2'b00);
    ticks(1248);
    check("rp_line", {h_cnt, v_cnt}, {12'd0, 11'd1});
    ticks(5 * 1248);
    check("rp_frame", {h_cnt, v_cnt}, {12'd0, 11'd0});
    ticks(20);
    check("rp_default", {h_cnt, v_cnt, cfg_pending}, {12'd20, 11'd0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
